ex_flag_pipe: RTL and testbench

- Sits directly downstream of the EX-stage ALU (ADD/SUB/XOR/RED/SLL/SRA/ROR/PADDSB datapaths).
- Registers the selected 16-bit ALU result into the EX/MEM pipeline latch.
- Maintains the architectural Z/V/N flag register, updated per opcode.
- Evaluates the 3-bit branch condition code against the committed flags for the branch unit.

---
 rtl/ex_flag_pipe_pkg.sv | 28 ++
 rtl/ex_flag_pipe_cond_eval.sv | 30 +++
 rtl/ex_flag_pipe.sv | 116 +++++++++++
 tb/tb_ex_flag_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_flag_pipe_pkg.sv
// Shared constants for the EX/MEM result latch and the branch condition logic.
//   - ALU opcode encodings (any opcode with bit 3 set is a non-ALU instruction)
//   - 3-bit branch condition codes
//   - default datapath / register-specifier widths
package ex_flag_pipe_pkg;

  localparam int unsigned DwDefault = 16;
  localparam int unsigned RwDefault = 4;

  localparam logic [3:0] OpAdd    = 4'b0000;
  localparam logic [3:0] OpSub    = 4'b0001;
  localparam logic [3:0] OpXor    = 4'b0010;
  localparam logic [3:0] OpRed    = 4'b0011;
  localparam logic [3:0] OpSll    = 4'b0100;
  localparam logic [3:0] OpSra    = 4'b0101;
  localparam logic [3:0] OpRor    = 4'b0110;
  localparam logic [3:0] OpPaddsb = 4'b0111;

  localparam logic [2:0] CondNe     = 3'b000;
  localparam logic [2:0] CondEq     = 3'b001;
  localparam logic [2:0] CondGt     = 3'b010;
  localparam logic [2:0] CondLt     = 3'b011;
  localparam logic [2:0] CondGte    = 3'b100;
  localparam logic [2:0] CondLte    = 3'b101;
  localparam logic [2:0] CondOvfl   = 3'b110;
  localparam logic [2:0] CondUncond = 3'b111;

endpackage

// File: rtl/ex_flag_pipe_cond_eval.sv
// Branch condition evaluator (purely combinational).
//   flag_z, flag_v, flag_n : committed flags
//   cond                   : 3-bit condition code
//   cond_true              : condition holds for the given flags
module ex_flag_pipe_cond_eval
  import ex_flag_pipe_pkg::*;
(
  input  logic       flag_z,
  input  logic       flag_v,
  input  logic       flag_n,
  input  logic [2:0] cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      CondNe:     cond_true = ~flag_z;
      CondEq:     cond_true = flag_z;
      CondGt:     cond_true = ~flag_z & ~flag_n;
      CondLt:     cond_true = flag_n;
      CondGte:    cond_true = flag_z | (~flag_z & ~flag_n);
      CondLte:    cond_true = flag_n | flag_z;
      CondOvfl:   cond_true = flag_v;
      CondUncond: cond_true = 1'b1;
      default:    cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_pipe.sv
// EX/MEM pipeline latch plus architectural Z/V/N flag register.
//   clk, rst              : clock, async active-high reset
//   ex_*                  : instruction leaving the EX-stage ALU
//   stall, flush          : hazard-unit controls (stall wins over flush)
//   cond                  : branch condition code from ID
//   mem_*                 : registered EX/MEM latch contents
//   flag_z/v/n            : committed flags
//   cond_true             : condition evaluated on committed flags only
module ex_flag_pipe
  import ex_flag_pipe_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned RW = RwDefault
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_ovfl,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wen,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    cond,
  output logic          mem_valid,
  output logic [DW-1:0] mem_result,
  output logic [RW-1:0] mem_rd,
  output logic          mem_wen,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          cond_true
);

  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          wen_q, wen_d;
  logic          z_q, z_d;
  logic          v_q, v_d;
  logic          n_q, n_d;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    wen_d    = wen_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;
    if (!stall) begin
      if (flush) begin
        // Bubble: payload fields keep their old contents, only valid/wen drop.
        valid_d = 1'b0;
        wen_d   = 1'b0;
      end else begin
        valid_d  = ex_valid;
        result_d = ex_result;
        rd_d     = ex_rd;
        wen_d    = ex_wen & ex_valid;
        if (ex_valid) begin
          case (ex_opcode)
            OpAdd, OpSub: begin
              // Result is already saturated, so a saturated sum never reads as zero.
              z_d = (ex_result == '0);
              n_d = ex_result[DW-1];
              v_d = ex_ovfl;
            end
            OpXor, OpSll, OpSra, OpRor: begin
              z_d = (ex_result == '0);
            end
            default: ; // RED, PADDSB and non-ALU opcodes leave flags alone
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wen_q    <= wen_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign mem_valid  = valid_q;
  assign mem_result = result_q;
  assign mem_rd     = rd_q;
  assign mem_wen    = wen_q;
  assign flag_z     = z_q;
  assign flag_v     = v_q;
  assign flag_n     = n_q;

  ex_flag_pipe_cond_eval u_cond_eval (
    .flag_z    (z_q),
    .flag_v    (v_q),
    .flag_n    (n_q),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_ex_flag_pipe.sv
module tb_ex_flag_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovfl;
  logic [3:0]  ex_rd;
  logic        ex_wen;
  logic        stall;
  logic        flush;
  logic [2:0]  cond;
  logic        mem_valid;
  logic [15:0] mem_result;
  logic [3:0]  mem_rd;
  logic        mem_wen;
  logic        flag_z, flag_v, flag_n;
  logic        cond_true;

  int tests = 0;
  int fails = 0;

  // Reference state
  logic        m_valid, m_wen, m_z, m_v, m_n;
  logic [15:0] m_result;
  logic [3:0]  m_rd;

  ex_flag_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_result  (ex_result),
    .ex_ovfl    (ex_ovfl),
    .ex_rd      (ex_rd),
    .ex_wen     (ex_wen),
    .stall      (stall),
    .flush      (flush),
    .cond       (cond),
    .mem_valid  (mem_valid),
    .mem_result (mem_result),
    .mem_rd     (mem_rd),
    .mem_wen    (mem_wen),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .cond_true  (cond_true)
  );

  always #5 clk = ~clk;

  function automatic logic model_cond(logic [2:0] c, logic z, logic n, logic v);
    logic [7:0] table_bits;
    // bit k = truth of condition code k
    table_bits = {1'b1, v, n | z, z | ~n, n, ~z & ~n, z, ~z};
    return table_bits[c];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".mem_valid"},  32'(mem_valid),  32'(m_valid));
    check({tag, ".mem_result"}, 32'(mem_result), 32'(m_result));
    check({tag, ".mem_rd"},     32'(mem_rd),     32'(m_rd));
    check({tag, ".mem_wen"},    32'(mem_wen),    32'(m_wen));
    check({tag, ".z"},          32'(flag_z),     32'(m_z));
    check({tag, ".v"},          32'(flag_v),     32'(m_v));
    check({tag, ".n"},          32'(flag_n),     32'(m_n));
    check({tag, ".cond_true"},  32'(cond_true),  32'(model_cond(cond, m_z, m_n, m_v)));
  endtask

  task automatic model_reset();
    m_valid = 0; m_wen = 0; m_result = '0; m_rd = '0; m_z = 0; m_v = 0; m_n = 0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic [3:0] rd, input logic wen,
                       input logic st, input logic fl);
    ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ov;
    ex_rd = rd; ex_wen = wen; stall = st; flush = fl;
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step(input string tag);
    if (!stall) begin
      if (flush) begin
        m_valid = 0;
        m_wen   = 0;
      end else begin
        m_valid  = ex_valid;
        m_result = ex_result;
        m_rd     = ex_rd;
        m_wen    = ex_wen & ex_valid;
        if (ex_valid && ex_opcode inside {4'd0, 4'd1}) begin
          m_z = (ex_result == 16'd0);
          m_n = ex_result[15];
          m_v = ex_ovfl;
        end else if (ex_valid && ex_opcode inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
          m_z = (ex_result == 16'd0);
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    cond = 3'b000;
    drive(0, 4'd0, 16'h0, 0, 4'h0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    check("reset.cond000", 32'(cond_true), 32'd1);
    rst = 1'b0;

    // ADD 0 then SUB 0x8000 with overflow
    drive(1, 4'd0, 16'h0000, 0, 4'h3, 1, 0, 0);
    step("add_zero");
    check("add_zero.z_const", 32'(flag_z), 32'd1);
    drive(1, 4'd1, 16'h8000, 1, 4'h4, 1, 0, 0);
    step("sub_neg");
    check("sub_neg.znv_const", {29'd0, flag_z, flag_n, flag_v}, 32'b011);
    cond = 3'b011;
    #1 check("sub_neg.lt", 32'(cond_true), 32'd1);
    cond = 3'b110;
    #1 check("sub_neg.ovfl", 32'(cond_true), 32'd1);

    // XOR sets only Z; RED / PADDSB leave flags alone
    drive(1, 4'd2, 16'h0000, 0, 4'h5, 1, 0, 0);
    step("xor_zero");
    check("xor_zero.znv_const", {29'd0, flag_z, flag_n, flag_v}, 32'b111);
    drive(1, 4'd3, 16'h0000, 0, 4'h6, 1, 0, 0);
    step("red");
    drive(1, 4'd7, 16'h1234, 1, 4'h7, 1, 0, 0);
    step("paddsb");
    check("paddsb.result_const", 32'(mem_result), 32'h1234);

    // Saturated ADD held by a two-cycle stall
    drive(1, 4'd0, 16'h7FFF, 0, 4'h8, 1, 1, 0);
    step("stall1");
    step("stall2");
    stall = 0;
    step("stall_release");
    check("stall_release.result_const", 32'(mem_result), 32'h7FFF);
    check("stall_release.zn_const", {30'd0, flag_z, flag_n}, 32'b00);

    // Flush: bubble inserted, Z untouched
    drive(1, 4'd0, 16'h0000, 0, 4'h9, 1, 0, 1);
    step("flush");
    check("flush.valid_wen_z", {29'd0, mem_valid, mem_wen, flag_z}, 32'b000);

    // Stall and flush together: full hold
    drive(1, 4'd0, 16'h0000, 1, 4'hA, 1, 1, 1);
    step("stall_flush");

    // Async reset mid-cycle with the latch loaded
    drive(1, 4'd1, 16'hFFFE, 1, 4'hB, 1, 0, 0);
    step("preload");
    #3 rst = 1'b1;
    model_reset();
    cond = 3'b000;
    #1 check_all("async_reset");
    check("async_reset.cond000", 32'(cond_true), 32'd1);
    cond = 3'b110;
    #1 check("async_reset.cond110", 32'(cond_true), 32'd0);
    drive(1, 4'd0, 16'h0000, 0, 4'hC, 1, 1, 1);
    #1 rst = 1'b0;
    step("post_reset_hold");

    // Sweep all condition codes over all flag combinations
    stall = 0; flush = 0;
    for (int f = 0; f < 8; f++) begin
      logic fz, fn, fv;
      fz = f[2]; fn = f[1]; fv = f[0];
      drive(1, 4'd0, fn ? 16'h8000 : (fz ? 16'h0000 : 16'h0001), fv, 4'h1, 0, 0, 0);
      step("sweep_set");
      if (fz && fn) begin
        drive(1, 4'd2, 16'h0000, 0, 4'h1, 0, 0, 0);
        step("sweep_xor");
      end
      for (int c = 0; c < 8; c++) begin
        cond = 3'(c);
        #1 check($sformatf("sweep.f%0d.c%0d", f, c), 32'(cond_true),
                 32'(model_cond(3'(c), fz, fn, fv)));
      end
    end

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom), 4'($urandom), 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      cond = 3'($urandom);
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
